row_normalizer_seq: RTL and testbench

- Parametrised, sequential successor to the fixed 1/sqrt2 row normaliser in the MIMO detector front end.
- Scales one channel-matrix row (N complex H entries) and its received sample y by a mode-selected constellation coefficient.
- Uses LANES time-shared round-to-nearest multipliers and valid/ready handshakes on both sides.
- Sits between the H/y input buffer and the QR/sorting stage.

---
 rtl/row_normalizer_seq_pkg.sv | 33 +++
 rtl/row_normalizer_seq_lane.sv | 29 ++
 rtl/row_normalizer_seq.sv | 147 ++++++++++++++
 tb/tb_row_normalizer_seq.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/row_normalizer_seq_pkg.sv
// Shared constants, encodings and coefficient lookup for the sequential row normaliser.
package row_normalizer_seq_pkg;

  localparam int unsigned CW_DEF = 16;

  // Q0.16 reciprocals of sqrt(2), sqrt(10) and sqrt(42).
  localparam logic [CW_DEF-1:0] C_SQ2  = 16'd46341;
  localparam logic [CW_DEF-1:0] C_SQ10 = 16'd20724;
  localparam logic [CW_DEF-1:0] C_SQ42 = 16'd10112;

  localparam logic [1:0] MODE_BYP  = 2'b00;
  localparam logic [1:0] MODE_SQ2  = 2'b01;
  localparam logic [1:0] MODE_SQ10 = 2'b10;
  localparam logic [1:0] MODE_SQ42 = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic [CW_DEF-1:0] mode_coef(input logic [1:0] m);
    logic [CW_DEF-1:0] c;
    case (m)
      MODE_SQ2:  c = C_SQ2;
      MODE_SQ10: c = C_SQ10;
      MODE_SQ42: c = C_SQ42;
      default:   c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/row_normalizer_seq_lane.sv
// Combinational rounding multiply: signed data by unsigned Q0.CW coefficient,
// round half up, or pass-through when bypass is set.
module norm_mul_lane #(
  parameter int unsigned WL = 16,
  parameter int unsigned CW = 16
) (
  input  logic [WL-1:0] din,
  input  logic [CW-1:0] coef,
  input  logic          bypass,
  output logic [WL-1:0] dout
);

  localparam int unsigned PW = WL + CW + 1;
  localparam logic signed [PW-1:0] HALF = PW'(1) << (CW - 1);

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] rnd;
  logic                 unused_bits;

  always_comb begin
    prod = PW'($signed(din)) * PW'($signed({1'b0, coef}));
    rnd  = prod + HALF;
    dout = bypass ? din : rnd[CW +: WL];
  end

  // Fraction bits and the guard bit are dropped; coef < 2^CW keeps the result in range.
  assign unused_bits = ^{rnd[CW-1:0], rnd[PW-1]};

endmodule

// File: rtl/row_normalizer_seq.sv
// Sequential row normaliser: captures one H row plus y, scales all 2N+2 reals
// through LANES shared multipliers, then holds the result until taken.
module row_normalizer_seq
  import row_normalizer_seq_pkg::*;
#(
  parameter int unsigned WL    = 16,
  parameter int unsigned N     = 4,
  parameter int unsigned LANES = 2,
  parameter int unsigned CW    = CW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      mode,
  input  logic [WL*N-1:0] Hin_x,
  input  logic [WL*N-1:0] Hin_y,
  input  logic [WL-1:0]   yin_x,
  input  logic [WL-1:0]   yin_y,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [WL*N-1:0] Hout_x,
  output logic [WL*N-1:0] Hout_y,
  output logic [WL-1:0]   yout_x,
  output logic [WL-1:0]   yout_y
);

  localparam int unsigned E     = 2 * N + 2;
  localparam int unsigned BEATS = (E + LANES - 1) / LANES;
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  state_e        state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [1:0]    mode_q, mode_d;
  logic [WL-1:0] in_buf_q [E];
  logic [WL-1:0] in_buf_d [E];
  logic [WL-1:0] res_q [E];
  logic [WL-1:0] res_d [E];
  logic [WL-1:0] out_q [E];
  logic [WL-1:0] out_d [E];
  logic [WL-1:0] lane_in [LANES];
  logic [WL-1:0] lane_out [LANES];
  logic [CW-1:0] coef;
  logic          bypass;
  logic          last_beat;

  assign coef      = CW'(mode_coef(mode_q));
  assign bypass    = (mode_q == MODE_BYP);
  assign last_beat = (beat_q == BW'(BEATS - 1));

  // Constant-index scan keeps the operand mux free of variable array selects.
  always_comb begin
    for (int j = 0; j < int'(LANES); j++) begin
      lane_in[j] = '0;
      for (int k = 0; k < int'(E); k++) begin
        if (int'(beat_q) * int'(LANES) + j == k) lane_in[j] = in_buf_q[k];
      end
    end
  end

  for (genvar g = 0; g < int'(LANES); g++) begin : g_lane
    norm_mul_lane #(
      .WL(WL),
      .CW(CW)
    ) u_lane (
      .din   (lane_in[g]),
      .coef  (coef),
      .bypass(bypass),
      .dout  (lane_out[g])
    );
  end

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    mode_d    = mode_q;
    in_buf_d  = in_buf_q;
    res_d     = res_q;
    out_d     = out_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          for (int i = 0; i < int'(N); i++) begin
            in_buf_d[i]     = Hin_x[WL*i +: WL];
            in_buf_d[N + i] = Hin_y[WL*i +: WL];
          end
          in_buf_d[2*N]     = yin_x;
          in_buf_d[2*N + 1] = yin_y;
          mode_d            = mode;
          beat_d            = '0;
          state_d           = S_BUSY;
        end
      end
      S_BUSY: begin
        for (int k = 0; k < int'(E); k++) begin
          for (int j = 0; j < int'(LANES); j++) begin
            if (int'(beat_q) * int'(LANES) + j == k) res_d[k] = lane_out[j];
          end
        end
        if (last_beat) begin
          out_d   = res_d;
          state_d = S_DONE;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      beat_q   <= '0;
      mode_q   <= '0;
      in_buf_q <= '{default: '0};
      res_q    <= '{default: '0};
      out_q    <= '{default: '0};
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      mode_q   <= mode_d;
      in_buf_q <= in_buf_d;
      res_q    <= res_d;
      out_q    <= out_d;
    end
  end

  always_comb begin
    Hout_x = '0;
    Hout_y = '0;
    for (int i = 0; i < int'(N); i++) begin
      Hout_x[WL*i +: WL] = out_q[i];
      Hout_y[WL*i +: WL] = out_q[N + i];
    end
    yout_x = out_q[2*N];
    yout_y = out_q[2*N + 1];
  end

endmodule

// File: tb/tb_row_normalizer_seq.sv
// Self-checking bench: directed scenarios on a LANES=2 instance plus a random
// sweep comparing LANES=2/1/3/10 instances against a real-arithmetic model.
module tb_row_normalizer_seq;

  localparam int WL = 16;
  localparam int N  = 4;
  localparam int E  = 2 * N + 2;
  localparam int ND = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [ND-1:0]   in_valid_v;
  logic [ND-1:0]   out_ready_v;
  logic [1:0]      mode;
  logic [WL*N-1:0] hin_x, hin_y;
  logic [WL-1:0]   yin_x, yin_y;
  logic            ir [ND];
  logic            ov [ND];
  logic [WL*N-1:0] hox [ND];
  logic [WL*N-1:0] hoy [ND];
  logic [WL-1:0]   yox [ND];
  logic [WL-1:0]   yoy [ND];

  int checks = 0;
  int errors = 0;
  int lanes_of [ND] = '{2, 1, 3, 10};
  logic [WL-1:0] cur [E];
  logic [1:0]    cur_mode;

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    row_normalizer_seq #(
      .WL   (WL),
      .N    (N),
      .LANES((g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 3 : 10),
      .CW   (16)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid_v[g]),
      .in_ready (ir[g]),
      .mode     (mode),
      .Hin_x    (hin_x),
      .Hin_y    (hin_y),
      .yin_x    (yin_x),
      .yin_y    (yin_y),
      .out_valid(ov[g]),
      .out_ready(out_ready_v[g]),
      .Hout_x   (hox[g]),
      .Hout_y   (hoy[g]),
      .yout_x   (yox[g]),
      .yout_y   (yoy[g])
    );
  end

  // Reference: value * (1/sqrt(M)) in Q0.16, rounded half up, using real arithmetic.
  function automatic logic [WL-1:0] ref_val(input logic [1:0] m, input logic [WL-1:0] v);
    real c;
    real r;
    int  ri;
    if (m == 2'b00) return v;
    c  = (m == 2'b01) ? 46341.0 : (m == 2'b10) ? 20724.0 : 10112.0;
    r  = $floor(real'($signed(v)) * c / 65536.0 + 0.5);
    ri = $rtoi(r);
    return ri[WL-1:0];
  endfunction

  function automatic logic [WL-1:0] dut_elem(input int d, input int k);
    if (k < N) return hox[d][WL*k +: WL];
    if (k < 2 * N) return hoy[d][WL*(k-N) +: WL];
    if (k == 2 * N) return yox[d];
    return yoy[d];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_row();
    for (int k = 0; k < E; k++) cur[k] = WL'($urandom);
  endtask

  task automatic zero_row();
    for (int k = 0; k < E; k++) cur[k] = '0;
  endtask

  task automatic apply_row(input logic [1:0] m);
    mode     = m;
    cur_mode = m;
    for (int i = 0; i < N; i++) begin
      hin_x[WL*i +: WL] = cur[i];
      hin_y[WL*i +: WL] = cur[N + i];
    end
    yin_x = cur[2*N];
    yin_y = cur[2*N + 1];
  endtask

  // Accept one row on instance d and count edges until out_valid (-1 on timeout).
  task automatic send(input int d, output int lat);
    in_valid_v[d] = 1'b1;
    step();
    in_valid_v[d] = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (ov[d]) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic release_row(input int d);
    out_ready_v[d] = 1'b1;
    step();
    out_ready_v[d] = 1'b0;
  endtask

  task automatic test_reset();
    #23 rst_n = 1'b1;
    step();
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (ir[d] !== 1'b1 || ov[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_hs dut%0d: in_ready=%b out_valid=%b, want 1/0", d, ir[d], ov[d]);
      end
      checks++;
      if ({hox[d], hoy[d], yox[d], yoy[d]} !== '0) begin
        errors++;
        $display("FAIL reset_data dut%0d: got %h, want 0", d, {hox[d], hoy[d], yox[d], yoy[d]});
      end
    end
  endtask

  task automatic test_sq2();
    int lat;
    zero_row();
    cur[0] = 16'd1000;
    cur[1] = -16'sd1000;
    cur[N] = 16'd32767;
    apply_row(2'b01);
    send(0, lat);
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL sq2_latency: got %0d, want 5", lat);
    end
    checks++;
    if (hox[0][15:0] !== 16'd707 || hox[0][31:16] !== 16'hFD3D || hoy[0][15:0] !== 16'd23170) begin
      errors++;
      $display("FAIL sq2_values: got %0d %0d %0d, want 707 -707 23170", $signed(hox[0][15:0]),
               $signed(hox[0][31:16]), $signed(hoy[0][15:0]));
    end
    for (int k = 0; k < E; k++) begin
      checks++;
      if (dut_elem(0, k) !== ref_val(cur_mode, cur[k])) begin
        errors++;
        $display("FAIL sq2_elem%0d: got %h, want %h", k, dut_elem(0, k), ref_val(cur_mode, cur[k]));
      end
    end
    release_row(0);
  endtask

  task automatic test_sq42_sq10();
    int lat;
    zero_row();
    cur[2*N]     = 16'h8000;
    cur[2*N + 1] = 16'd1;
    apply_row(2'b11);
    send(0, lat);
    checks++;
    if (lat !== 5 || yox[0] !== 16'hEC40 || yoy[0] !== 16'd0) begin
      errors++;
      $display("FAIL sq42_y: lat=%0d y=%0d,%0d, want 5 -5056,0", lat, $signed(yox[0]),
               $signed(yoy[0]));
    end
    release_row(0);
    zero_row();
    cur[2*N] = 16'd10000;
    apply_row(2'b10);
    send(0, lat);
    checks++;
    if (lat !== 5 || yox[0] !== 16'd3162) begin
      errors++;
      $display("FAIL sq10_y: lat=%0d y=%0d, want 5 3162", lat, $signed(yox[0]));
    end
    release_row(0);
  endtask

  task automatic test_bypass();
    int lat;
    for (int r = 0; r < 3; r++) begin
      rand_row();
      apply_row(2'b00);
      send(0, lat);
      checks++;
      if (lat !== 5) begin
        errors++;
        $display("FAIL bypass_latency: got %0d, want 5", lat);
      end
      for (int k = 0; k < E; k++) begin
        checks++;
        if (dut_elem(0, k) !== cur[k]) begin
          errors++;
          $display("FAIL bypass_elem%0d: got %h, want %h", k, dut_elem(0, k), cur[k]);
        end
      end
      release_row(0);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [2*WL*N+2*WL-1:0] held;
    rand_row();
    apply_row(2'(1 + $urandom_range(0, 2)));
    send(0, lat);
    held = {hox[0], hoy[0], yox[0], yoy[0]};
    for (int c = 0; c < 10; c++) begin
      hin_x = {$urandom, $urandom};
      hin_y = {$urandom, $urandom};
      yin_x = WL'($urandom);
      yin_y = WL'($urandom);
      mode  = 2'($urandom);
      in_valid_v[0] = 1'b1;
      step();
      checks++;
      if (ov[0] !== 1'b1 || ir[0] !== 1'b0 || {hox[0], hoy[0], yox[0], yoy[0]} !== held) begin
        errors++;
        $display("FAIL bp_hold cyc%0d: ov=%b ir=%b data=%h, want 1 0 %h", c, ov[0], ir[0],
                 {hox[0], hoy[0], yox[0], yoy[0]}, held);
      end
    end
    rand_row();
    apply_row(2'(1 + $urandom_range(0, 2)));
    out_ready_v[0] = 1'b1;
    step();
    out_ready_v[0] = 1'b0;
    checks++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1 || {hox[0], hoy[0], yox[0], yoy[0]} !== held) begin
      errors++;
      $display("FAIL bp_release: ov=%b ir=%b data=%h, want 0 1 %h", ov[0], ir[0],
               {hox[0], hoy[0], yox[0], yoy[0]}, held);
    end
    step();
    in_valid_v[0] = 1'b0;
    checks++;
    if (ir[0] !== 1'b0) begin
      errors++;
      $display("FAIL bp_accept_next: in_ready=%b, want 0", ir[0]);
    end
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (ov[0]) begin
        lat = c;
        break;
      end
    end
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL bp_latency: got %0d, want 5", lat);
    end
    for (int k = 0; k < E; k++) begin
      checks++;
      if (dut_elem(0, k) !== ref_val(cur_mode, cur[k])) begin
        errors++;
        $display("FAIL bp_elem%0d: got %h, want %h", k, dut_elem(0, k), ref_val(cur_mode, cur[k]));
      end
    end
    release_row(0);
  endtask

  task automatic test_reset_mid_busy();
    rand_row();
    apply_row(2'b01);
    in_valid_v[0] = 1'b1;
    step();
    in_valid_v[0] = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1 || {hox[0], hoy[0], yox[0], yoy[0]} !== '0) begin
      errors++;
      $display("FAIL reset_mid: ov=%b ir=%b data=%h, want 0 1 0", ov[0], ir[0],
               {hox[0], hoy[0], yox[0], yoy[0]});
    end
    #3 rst_n = 1'b1;
    step();
    step();
    checks++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_after: ov=%b ir=%b, want 0 1", ov[0], ir[0]);
    end
  endtask

  task automatic test_lane_sweep();
    int lat [ND];
    for (int r = 0; r < 1000; r++) begin
      rand_row();
      apply_row(2'($urandom));
      in_valid_v = '1;
      step();
      in_valid_v = '0;
      for (int d = 0; d < ND; d++) lat[d] = -1;
      for (int c = 1; c <= 15; c++) begin
        step();
        for (int d = 0; d < ND; d++) begin
          if (lat[d] < 0 && ov[d]) begin
            lat[d] = c;
            for (int k = 0; k < E; k++) begin
              if (dut_elem(d, k) !== ref_val(cur_mode, cur[k])) begin
                errors++;
                $display("FAIL sweep_data row%0d lanes%0d elem%0d: got %h, want %h", r,
                         lanes_of[d], k, dut_elem(d, k), ref_val(cur_mode, cur[k]));
                break;
              end
            end
            checks++;
          end
        end
      end
      for (int d = 0; d < ND; d++) begin
        checks++;
        if (lat[d] !== (E + lanes_of[d] - 1) / lanes_of[d]) begin
          errors++;
          $display("FAIL sweep_latency row%0d lanes%0d: got %0d, want %0d", r, lanes_of[d],
                   lat[d], (E + lanes_of[d] - 1) / lanes_of[d]);
        end
      end
      out_ready_v = '1;
      step();
      out_ready_v = '0;
    end
  endtask

  initial begin
    in_valid_v  = '0;
    out_ready_v = '0;
    mode        = '0;
    hin_x       = '0;
    hin_y       = '0;
    yin_x       = '0;
    yin_y       = '0;
    cur_mode    = '0;
    test_reset();
    test_sq2();
    test_sq42_sq10();
    test_bypass();
    test_backpressure();
    test_reset_mid_busy();
    test_lane_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
